// File: rtl/mealy_mac_chan_if.sv
// mealy_mac_chan_if: beat-in / result-out bundle for mealy_mac_chan.
// The channel-select width is derived here so that both sides agree on it.
interface mealy_mac_chan_if #(
  parameter int WIDTH     = 9,
  parameter int ACC_WIDTH = 18,
  parameter int CHANNELS  = 4
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                        in_valid;
  logic [CHAN_W-1:0]           in_chan;
  logic signed [WIDTH-1:0]     in_x;
  logic signed [WIDTH-1:0]     in_y;
  logic                        in_clear;
  logic                        out_valid;
  logic [CHAN_W-1:0]           out_chan;
  logic signed [ACC_WIDTH-1:0] out_acc;
  logic                        out_ovf;

  modport master (
    output in_valid, in_chan, in_x, in_y, in_clear,
    input  out_valid, out_chan, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_chan, in_x, in_y, in_clear,
    output out_valid, out_chan, out_acc, out_ovf
  );
endinterface

// File: rtl/mealy_mac_chan.sv
// mealy_mac_chan: CHANNELS independent signed MAC accumulators, one channel
// updated per valid beat (acc <= acc + x*y, or x*y when cleared). The result
// beat carries the channel's pre-update value one cycle later (Mealy
// "output old state, store new state").
// Optional build macro MEALY_MAC_SATURATE_EN: clamp the stored accumulator
// on overflow instead of two's-complement wrap. out_ovf is the same either way.

// One accumulator register; the top decides when and what to write.
module mealy_mac_chan_lane #(
  parameter int ACC_WIDTH = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [ACC_WIDTH-1:0] i_wdata,
  output logic [ACC_WIDTH-1:0] o_acc
);
  logic [ACC_WIDTH-1:0] r_acc;

  // Accumulator state, cleared by the asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_acc <= '0;
    else if (i_we) r_acc <= i_wdata;
  end

  assign o_acc = r_acc;
endmodule

module mealy_mac_chan #(
  parameter int WIDTH     = 9,
  parameter int ACC_WIDTH = 18,
  parameter int CHANNELS  = 4
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  mealy_mac_chan_if.slave  bus
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW     = 2 * WIDTH;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // The sum must hold any full-width product without loss.
  if (ACC_WIDTH < PW) begin : g_width_chk
    $error("mealy_mac_chan: ACC_WIDTH must be at least 2*WIDTH");
  end

  logic [CHANNELS-1:0][ACC_WIDTH-1:0] w_acc;
  logic signed [PW-1:0]               w_prod;
  logic signed [ACC_WIDTH:0]          w_prod_ext;
  logic [ACC_WIDTH-1:0]               w_old;
  logic [ACC_WIDTH-1:0]               w_base;
  logic signed [ACC_WIDTH:0]          w_sum;
  logic                               w_ovf;
  logic                               w_in_range;
  logic [ACC_WIDTH-1:0]               w_wdata;

  logic                               r_out_valid;
  logic [CHAN_W-1:0]                  r_out_chan;
  logic [ACC_WIDTH-1:0]               r_out_acc;
  logic                               r_out_ovf;

  // Only reachable when CHANNELS is not a power of two.
  assign w_in_range = ({1'b0, bus.in_chan} < (CHAN_W+1)'(CHANNELS));

  // Old value of the selected channel; zero for an unpopulated channel index.
  always_comb begin
    w_old = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (bus.in_chan == CHAN_W'(c)) w_old = w_acc[c];
  end

  assign w_prod     = bus.in_x * bus.in_y;
  assign w_prod_ext = {{(ACC_WIDTH+1-PW){w_prod[PW-1]}}, w_prod};
  assign w_base     = bus.in_clear ? '0 : w_old;
  // One guard bit is enough: |product| <= 2^(PW-2) fits under the extra bit.
  assign w_sum      = $signed({w_base[ACC_WIDTH-1], w_base}) + w_prod_ext;
  assign w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

`ifdef MEALY_MAC_SATURATE_EN
  // Clamp toward the sign of the true (guard-bit) sum.
  assign w_wdata = w_ovf ? (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                         : w_sum[ACC_WIDTH-1:0];
`else
  assign w_wdata = w_sum[ACC_WIDTH-1:0];
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    mealy_mac_chan_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .i_clk   (system1000),
      .i_rst_n (system1000_rstn),
      .i_we    (bus.in_valid && w_in_range && (bus.in_chan == CHAN_W'(c))),
      .i_wdata (w_wdata),
      .o_acc   (w_acc[c])
    );
  end

  // Result beat: old value of the channel, held while no beat arrives.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_chan <= bus.in_chan;
        r_out_acc  <= w_in_range ? w_old : '0;
        r_out_ovf  <= w_in_range && w_ovf;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_mealy_mac_chan.sv
// tb_mealy_mac_chan: directed plan plus randomized beats; expected results
// come from an arithmetic reference model and are checked by a monitor.
module tb_mealy_mac_chan;
  localparam int W  = 9;
  localparam int AW = 18;
  localparam int CH = 4;
  localparam longint MAXV = (longint'(1) << (AW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW-1));

  typedef struct {
    int     chan;
    longint acc;
    bit     ovf;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  mealy_mac_chan_if #(.WIDTH(W), .ACC_WIDTH(AW), .CHANNELS(CH)) bus ();

  mealy_mac_chan #(.WIDTH(W), .ACC_WIDTH(AW), .CHANNELS(CH)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus)
  );

  exp_t   q[$];
  longint m_acc[CH];
  int     checks = 0;
  int     errors = 0;
  bit     end_req = 1'b0;

  // Reference model helpers: plain arithmetic on 64-bit integers.
  function automatic longint wrap(longint s);
    longint m = longint'(1) << AW;
    longint r = (s - MINV) % m;
    if (r < 0) r += m;
    return r + MINV;
  endfunction

  function automatic longint resolve(longint s);
`ifdef MEALY_MAC_SATURATE_EN
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
`else
    return wrap(s);
`endif
  endfunction

  task automatic beat(int ch, int x, int y, bit clr);
    exp_t   e;
    longint old, s;
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'(ch);
    bus.in_x     = 9'(x);
    bus.in_y     = 9'(y);
    bus.in_clear = clr;
    old    = m_acc[ch];
    s      = (clr ? 0 : old) + longint'(x) * longint'(y);
    e.chan = ch;
    e.acc  = old;
    e.ovf  = (s > MAXV) || (s < MINV);
    q.push_back(e);
    m_acc[ch] = resolve(s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Idle cycle with junk on the data pins (in_clear alone must be ignored).
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_clear = 1'($urandom_range(0, 1));
    bus.in_chan  = 2'($urandom_range(0, CH-1));
    bus.in_x     = 9'($urandom_range(0, 511));
    bus.in_y     = 9'($urandom_range(0, 511));
    @(posedge clk); #1;
  endtask

  // Reset asserted between edges; the in-flight result is discarded.
  task automatic mid_reset();
    #1 rstn = 1'b0;
    q.delete();
    for (int i = 0; i < CH; i++) m_acc[i] = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  function automatic int rnd_op();
    case ($urandom_range(0, 7))
      0: return -256;
      1: return 255;
      default: return int'($urandom_range(0, 511)) - 256;
    endcase
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset values, scoreboard pops on result beats, hold otherwise.
  longint last_acc  = 0;
  int     last_chan = 0;
  bit     last_ovf  = 1'b0;
  exp_t   me;

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_valid", longint'(bus.out_valid), 0);
      chk("rst_chan",  longint'(bus.out_chan), 0);
      chk("rst_acc",   longint'($signed(bus.out_acc)), 0);
      chk("rst_ovf",   longint'(bus.out_ovf), 0);
      last_acc  = 0;
      last_chan = 0;
      last_ovf  = 1'b0;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat act=valid exp=idle t=%0t", $time);
      end else begin
        me = q.pop_front();
        chk("chan", longint'(bus.out_chan), longint'(me.chan));
        chk("acc",  longint'($signed(bus.out_acc)), me.acc);
        chk("ovf",  longint'(bus.out_ovf), longint'(me.ovf));
        last_acc  = me.acc;
        last_chan = me.chan;
        last_ovf  = me.ovf;
      end
    end else begin
      chk("hold_acc",  longint'($signed(bus.out_acc)), last_acc);
      chk("hold_chan", longint'(bus.out_chan), longint'(last_chan));
      chk("hold_ovf",  longint'(bus.out_ovf), longint'(last_ovf));
    end
    if (end_req) chk("drain", longint'(q.size()), 0);
  end

  initial begin
    for (int i = 0; i < CH; i++) m_acc[i] = 0;
    bus.in_valid = 1'b0;
    bus.in_chan  = '0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_clear = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle();

    // Consecutive beats on ch0.
    beat(0, 3, 4, 0); beat(0, -2, 5, 0); beat(0, 10, 10, 0);
    // Interleaved channels.
    beat(1, 7, 7, 0); beat(2, -1, 1, 0); beat(1, 1, 1, 0); beat(3, 0, 255, 0);
    // Clear replaces the accumulator, then read it back.
    beat(0, 2, 3, 1); beat(0, 0, 0, 0);
    // Overflow on ch2 from zero, then read the stored value.
    beat(2, 0, 0, 1); beat(2, -256, -256, 0); beat(2, -256, -256, 0);
    beat(2, 0, 0, 0);
    // Gap with hold, then same channel again.
    beat(3, 2, 2, 0); idle(); idle(); idle(); beat(3, 1, 1, 0);
    // Reset with a ch1 beat in flight; next ch1 beat sees 0.
    beat(1, 0, 0, 0);
    mid_reset();
    beat(1, 1, 1, 0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) mid_reset();
      if ($urandom_range(0, 3) != 0)
        beat(int'($urandom_range(0, CH-1)), rnd_op(), rnd_op(),
             $urandom_range(0, 7) == 0);
      else
        idle();
    end

    idle(); idle();
    end_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
